axi4_stream_pkt_arbiter: RTL and testbench

AXI4_STREAM_PKT_ARBITER -- requirements
Module: axi4_stream_pkt_arbiter

---
 rtl/axi4_stream_arb_pkg.sv | 19 +
 rtl/axi4_stream_if.sv | 28 ++
 rtl/rr_prio_encoder.sv | 27 ++
 rtl/axi4_stream_pkt_arbiter.sv | 116 +++++++++++
 tb/tb_axi4_stream_pkt_arbiter.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_stream_arb_pkg.sv
// Shared types and constants for the AXI4-Stream packet arbiter slice.
// The sideband widths are fixed here so that every port agrees on them.
package axi4_stream_arb_pkg;

    localparam int TUSER_WIDTH = 1;
    localparam int TDEST_WIDTH = 4;
    localparam int TID_WIDTH   = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Port index reached by stepping 'offset' ports past 'base', wrapping at 'modulus'.
    function automatic int wrap_index(input int base, input int offset, input int modulus);
        return (base + offset) % modulus;
    endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle; master drives the payload, slave drives tready.
interface axi4_stream_if
    import axi4_stream_arb_pkg::*;
#(
    parameter int TDATA_WIDTH = 32
);

    logic                     tvalid;
    logic                     tready;
    logic [TDATA_WIDTH-1:0]   tdata;
    logic [TDATA_WIDTH/8-1:0] tstrb;
    logic [TDATA_WIDTH/8-1:0] tkeep;
    logic                     tlast;
    logic [TUSER_WIDTH-1:0]   tuser;
    logic [TDEST_WIDTH-1:0]   tdest;
    logic [TID_WIDTH-1:0]     tid;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid,
        output tready
    );

endinterface

// File: rtl/rr_prio_encoder.sv
// Round-robin priority encoder: scans requests starting one past the last grant,
// wrapping modulo PORTS_AMOUNT; the lowest offset that requests wins.
module rr_prio_encoder
    import axi4_stream_arb_pkg::*;
#(
    parameter  int PORTS_AMOUNT = 4,
    localparam int GRANT_WIDTH  = $clog2(PORTS_AMOUNT)
) (
    input  logic [PORTS_AMOUNT-1:0] req,
    input  logic [GRANT_WIDTH-1:0]  last_grant,
    output logic [GRANT_WIDTH-1:0]  winner,
    output logic                    valid
);

    always_comb begin
        // NOTE: outputs get defaults before the loop so no path leaves them unassigned (no latch).
        winner = '0;
        valid  = 1'b0;
        for (int off = 1; off <= PORTS_AMOUNT; off++) begin
            if (!valid && req[wrap_index(int'(last_grant), off, PORTS_AMOUNT)]) begin
                valid  = 1'b1;
                winner = GRANT_WIDTH'(wrap_index(int'(last_grant), off, PORTS_AMOUNT));
            end
        end
    end

endmodule

// File: rtl/axi4_stream_pkt_arbiter.sv
// Packet-granular AXI4-Stream arbiter: locks one requesting port for a whole
// packet, forwards it with zero latency, and re-arbitrates round-robin after tlast.
module axi4_stream_pkt_arbiter
    import axi4_stream_arb_pkg::*;
#(
    parameter  int TDATA_WIDTH  = 32,
    parameter  int PORTS_AMOUNT = 4,
    localparam int GRANT_WIDTH  = $clog2(PORTS_AMOUNT),
    localparam int KEEP_WIDTH   = TDATA_WIDTH / 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    axi4_stream_if.slave           pkt_i [PORTS_AMOUNT],
    axi4_stream_if.master          pkt_o,
    output logic [GRANT_WIDTH-1:0] grant_o,
    output logic                   busy_o
);

    arb_state_t             state;
    arb_state_t             state_next;
    logic [GRANT_WIDTH-1:0] grant_next;
    logic [GRANT_WIDTH-1:0] last_grant;
    logic [GRANT_WIDTH-1:0] last_grant_next;

    logic                   arb_valid;
    logic [GRANT_WIDTH-1:0] arb_winner;
    logic                   locked;
    logic                   fwd_tvalid;
    logic                   fwd_tlast;
    logic                   tail_beat;

    // Interface arrays only allow constant indices, so each port is flattened here.
    logic [PORTS_AMOUNT-1:0] in_tvalid;
    logic [PORTS_AMOUNT-1:0] in_tlast;
    logic [TDATA_WIDTH-1:0]  in_tdata [PORTS_AMOUNT];
    logic [KEEP_WIDTH-1:0]   in_tstrb [PORTS_AMOUNT];
    logic [KEEP_WIDTH-1:0]   in_tkeep [PORTS_AMOUNT];
    logic [TUSER_WIDTH-1:0]  in_tuser [PORTS_AMOUNT];
    logic [TDEST_WIDTH-1:0]  in_tdest [PORTS_AMOUNT];
    logic [TID_WIDTH-1:0]    in_tid   [PORTS_AMOUNT];

    assign locked = (state == LOCKED);
    assign busy_o = locked;

    for (genvar k = 0; k < PORTS_AMOUNT; k++) begin : g_port
        assign in_tvalid[k] = pkt_i[k].tvalid;
        assign in_tlast[k]  = pkt_i[k].tlast;
        assign in_tdata[k]  = pkt_i[k].tdata;
        assign in_tstrb[k]  = pkt_i[k].tstrb;
        assign in_tkeep[k]  = pkt_i[k].tkeep;
        assign in_tuser[k]  = pkt_i[k].tuser;
        assign in_tdest[k]  = pkt_i[k].tdest;
        assign in_tid[k]    = pkt_i[k].tid;
        // Only the locked port ever sees the sink's tready; everyone else stalls.
        assign pkt_i[k].tready = locked && (grant_o == GRANT_WIDTH'(k)) && pkt_o.tready;
    end

    rr_prio_encoder #(
        .PORTS_AMOUNT (PORTS_AMOUNT)
    ) u_rr_prio_encoder (
        .req        (in_tvalid),
        .last_grant (last_grant),
        .winner     (arb_winner),
        .valid      (arb_valid)
    );

    // Zero-latency output mux driven from the registered grant only.
    assign fwd_tvalid = locked && in_tvalid[grant_o];
    assign fwd_tlast  = in_tlast[grant_o];
    assign tail_beat  = fwd_tvalid && pkt_o.tready && fwd_tlast;

    assign pkt_o.tvalid = fwd_tvalid;
    assign pkt_o.tlast  = fwd_tlast;
    assign pkt_o.tdata  = in_tdata[grant_o];
    assign pkt_o.tstrb  = in_tstrb[grant_o];
    assign pkt_o.tkeep  = in_tkeep[grant_o];
    assign pkt_o.tuser  = in_tuser[grant_o];
    assign pkt_o.tdest  = in_tdest[grant_o];
    assign pkt_o.tid    = in_tid[grant_o];

    always_comb begin
        state_next      = state;
        grant_next      = grant_o;
        last_grant_next = last_grant;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_next = LOCKED;
                    grant_next = arb_winner;
                end
            end
            LOCKED: begin
                // Gaps in tvalid keep the lock; only the tlast handshake releases it.
                if (tail_beat) begin
                    state_next      = IDLE;
                    last_grant_next = grant_o;
                end
            end
        endcase
    end

    // last_grant resets to the final port so that port 0 wins the first arbitration.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            grant_o    <= '0;
            last_grant <= GRANT_WIDTH'(PORTS_AMOUNT - 1);
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state      <= state_next;
            grant_o    <= grant_next;
            last_grant <= last_grant_next;
        end
    end

endmodule

// File: tb/tb_axi4_stream_pkt_arbiter.sv
// Scoreboard bench for axi4_stream_pkt_arbiter: a 4-port instance for the main
// scenarios and a 3-port instance for non-power-of-two wrap-around.
module tb_axi4_stream_pkt_arbiter;
    import axi4_stream_arb_pkg::*;

    localparam int DW  = 32;
    localparam int KW  = DW / 8;
    localparam int NP  = 4;
    localparam int GW  = $clog2(NP);
    localparam int NP3 = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [7:0]    port;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 4-port instance
    axi4_stream_if #(.TDATA_WIDTH(DW)) pkt_in [NP] ();
    axi4_stream_if #(.TDATA_WIDTH(DW)) pkt_out ();
    logic [GW-1:0] grant;
    logic          busy;

    logic [NP-1:0] src_valid;
    logic [NP-1:0] src_last;
    logic [DW-1:0] src_data [NP];
    logic [KW-1:0] src_keep [NP];
    logic [NP-1:0] rdy;
    logic          sink_ready;

    for (genvar k = 0; k < NP; k++) begin : g_src
        assign pkt_in[k].tvalid = src_valid[k];
        assign pkt_in[k].tdata  = src_data[k];
        assign pkt_in[k].tstrb  = src_keep[k];
        assign pkt_in[k].tkeep  = src_keep[k];
        assign pkt_in[k].tlast  = src_last[k];
        assign pkt_in[k].tuser  = '0;
        assign pkt_in[k].tdest  = TDEST_WIDTH'(k);
        assign pkt_in[k].tid    = TID_WIDTH'(k);
        assign rdy[k]           = pkt_in[k].tready;
    end
    assign pkt_out.tready = sink_ready;

    axi4_stream_pkt_arbiter #(
        .TDATA_WIDTH  (DW),
        .PORTS_AMOUNT (NP)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .pkt_i   (pkt_in),
        .pkt_o   (pkt_out),
        .grant_o (grant),
        .busy_o  (busy)
    );

    // 3-port instance, single-beat packets only
    axi4_stream_if #(.TDATA_WIDTH(DW)) pkt3_in [NP3] ();
    axi4_stream_if #(.TDATA_WIDTH(DW)) pkt3_out ();
    logic [1:0]     grant3;
    logic           busy3;
    logic [NP3-1:0] v3;
    logic [NP3-1:0] rdy3;

    for (genvar k = 0; k < NP3; k++) begin : g_src3
        assign pkt3_in[k].tvalid = v3[k];
        assign pkt3_in[k].tdata  = DW'(k);
        assign pkt3_in[k].tstrb  = '1;
        assign pkt3_in[k].tkeep  = '1;
        assign pkt3_in[k].tlast  = 1'b1;
        assign pkt3_in[k].tuser  = '0;
        assign pkt3_in[k].tdest  = TDEST_WIDTH'(k);
        assign pkt3_in[k].tid    = TID_WIDTH'(k);
        assign rdy3[k]           = pkt3_in[k].tready;
    end
    assign pkt3_out.tready = 1'b1;

    axi4_stream_pkt_arbiter #(
        .TDATA_WIDTH  (DW),
        .PORTS_AMOUNT (NP3)
    ) dut3 (
        .clk_i   (clk),
        .rst_i   (rst),
        .pkt_i   (pkt3_in),
        .pkt_o   (pkt3_out),
        .grant_o (grant3),
        .busy_o  (busy3)
    );

    beat_t         src_q [NP][$];
    exp_t          exp_q[$];
    int            hs_cyc[$];
    logic [NP-1:0] hold;
    logic          bp_toggle;
    int            checks    = 0;
    int            failures  = 0;
    int            cycle     = 0;
    int            out_beats = 0;

    task automatic drive_update();
        beat_t b;
        for (int k = 0; k < NP; k++) begin
            if (src_q[k].size() > 0 && !hold[k]) begin
                b            = src_q[k][0];
                src_valid[k] = 1'b1;
                src_data[k]  = b.data;
                src_keep[k]  = b.keep;
                src_last[k]  = b.last;
            end else begin
                src_valid[k] = 1'b0;
                src_data[k]  = '0;
                src_keep[k]  = '0;
                src_last[k]  = 1'b0;
            end
        end
    endtask

    // Queue a packet at a source and its beats on the scoreboard, in expected output order.
    task automatic add_pkt(input int p, input int nbeats, input int tag);
        beat_t b;
        exp_t  e;
        for (int i = 0; i < nbeats; i++) begin
            b.data = {8'(p), 8'(tag), 8'(i), 8'($urandom_range(255))};
            b.keep = (i == nbeats - 1) ? KW'($urandom_range(1, 15)) : '1;
            b.last = (i == nbeats - 1);
            src_q[p].push_back(b);
            e.port = 8'(p);
            e.data = b.data;
            e.keep = b.keep;
            e.last = b.last;
            exp_q.push_back(e);
        end
    endtask

    // One clock: sample handshakes at negedge, score output beats, advance sources after posedge.
    task automatic tick();
        logic [NP-1:0] hs_in;
        exp_t          e;
        @(negedge clk);
        cycle++;
        hs_in = src_valid & rdy;
        if (pkt_out.tvalid && sink_ready) begin
            out_beats++;
            hs_cyc.push_back(cycle);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat: got port=%0d data=%h, want no beat", grant, pkt_out.tdata);
            end else begin
                e = exp_q.pop_front();
                if (pkt_out.tdata !== e.data || pkt_out.tkeep !== e.keep || pkt_out.tstrb !== e.keep ||
                    pkt_out.tlast !== e.last || pkt_out.tid !== TID_WIDTH'(e.port) || grant !== GW'(e.port)) begin
                    failures++;
                    $display("FAIL beat_%0d: got grant=%0d tid=%0d data=%h keep=%h last=%b, want port=%0d data=%h keep=%h last=%b",
                             out_beats, grant, pkt_out.tid, pkt_out.tdata, pkt_out.tkeep, pkt_out.tlast,
                             e.port, e.data, e.keep, e.last);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NP; k++) if (hs_in[k]) void'(src_q[k].pop_front());
        if (bp_toggle) sink_ready = !sink_ready;
        drive_update();
    endtask

    task automatic run_until_empty(input int budget, input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: got %0d beats pending after %0d cycles, want 0", name, exp_q.size(), budget);
        end
        repeat (4) tick();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        for (int k = 0; k < NP; k++) src_q[k].delete();
        exp_q.delete();
        hold       = '0;
        bp_toggle  = 1'b0;
        sink_ready = 1'b1;
        v3         = '0;
        drive_update();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        hs_cyc.delete();
        out_beats = 0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        sink_ready = 1'b0;
        hold       = '0;
        bp_toggle  = 1'b0;
        v3         = '0;
        for (int p = 0; p < NP; p++) add_pkt(p, 1, 0);
        exp_q.delete();
        drive_update();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, want 0", busy); end
        checks++;
        if (grant !== '0) begin failures++; $display("FAIL reset_grant: got %0d, want 0", grant); end
        checks++;
        if (pkt_out.tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %b, want 0", pkt_out.tvalid); end
        checks++;
        if (rdy !== '0) begin failures++; $display("FAIL reset_tready: got %b, want 0000", rdy); end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1 || grant !== GW'(0)) begin
            failures++;
            $display("FAIL first_grant: got busy=%b grant=%0d, want busy=1 grant=0", busy, grant);
        end
    endtask

    task automatic test_two_ports();
        int gap_exp [5] = '{1, 1, 2, 1, 1};
        apply_reset();
        add_pkt(0, 3, 1);
        add_pkt(2, 3, 2);
        drive_update();
        run_until_empty(40, "two_ports");
        checks++;
        if (hs_cyc.size() != 6) begin
            failures++;
            $display("FAIL two_ports_count: got %0d beats, want 6", hs_cyc.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (hs_cyc[i+1] - hs_cyc[i] != gap_exp[i]) begin
                    failures++;
                    $display("FAIL two_ports_gap_%0d: got %0d cycles, want %0d", i, hs_cyc[i+1] - hs_cyc[i], gap_exp[i]);
                end
            end
        end
    endtask

    task automatic test_rr_single_beat();
        apply_reset();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NP; p++) add_pkt(p, 1, 16 + r);
        drive_update();
        run_until_empty(60, "rr_single");
        checks++;
        if (hs_cyc.size() != 8) begin
            failures++;
            $display("FAIL rr_single_count: got %0d beats, want 8", hs_cyc.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (hs_cyc[i+1] - hs_cyc[i] != 2) begin
                    failures++;
                    $display("FAIL rr_single_gap_%0d: got %0d cycles, want 2", i, hs_cyc[i+1] - hs_cyc[i]);
                end
            end
        end
    endtask

    task automatic test_lock_hold();
        int n = 0;
        apply_reset();
        add_pkt(1, 5, 3);
        add_pkt(3, 2, 4);
        drive_update();
        while (out_beats < 2 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (out_beats != 2) begin
            failures++;
            $display("FAIL lock_hold_start: got %0d beats, want 2", out_beats);
        end
        hold[1] = 1'b1;
        drive_update();
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (busy !== 1'b1 || grant !== GW'(1) || rdy[3] !== 1'b0) begin
                failures++;
                $display("FAIL lock_hold_gap_%0d: got busy=%b grant=%0d tready3=%b, want busy=1 grant=1 tready3=0",
                         c, busy, grant, rdy[3]);
            end
        end
        hold[1] = 1'b0;
        drive_update();
        run_until_empty(40, "lock_hold");
    endtask

    task automatic test_backpressure();
        apply_reset();
        add_pkt(0, 4, 5);
        bp_toggle = 1'b1;
        drive_update();
        run_until_empty(40, "backpressure");
        bp_toggle  = 1'b0;
        sink_ready = 1'b1;
        checks++;
        if (hs_cyc.size() != 4) begin
            failures++;
            $display("FAIL backpressure_count: got %0d beats, want 4", hs_cyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (hs_cyc[i+1] - hs_cyc[i] != 2) begin
                    failures++;
                    $display("FAIL backpressure_gap_%0d: got %0d cycles, want 2", i, hs_cyc[i+1] - hs_cyc[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int    n = 0;
        beat_t b;
        exp_t  e;
        apply_reset();
        add_pkt(2, 4, 6);
        drive_update();
        while (out_beats < 2 && n < 20) begin
            tick();
            n++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || pkt_out.tvalid !== 1'b0 || rdy !== '0 || grant !== '0) begin
            failures++;
            $display("FAIL reset_mid: got busy=%b tvalid=%b tready=%b grant=%0d, want 0 0 0000 0",
                     busy, pkt_out.tvalid, rdy, grant);
        end
        // Port 2 still offers its two remaining beats; port 0 must be served first.
        exp_q.delete();
        add_pkt(0, 2, 7);
        for (int i = 0; i < src_q[2].size(); i++) begin
            b      = src_q[2][i];
            e.port = 8'd2;
            e.data = b.data;
            e.keep = b.keep;
            e.last = b.last;
            exp_q.push_back(e);
        end
        drive_update();
        repeat (2) tick();
        rst = 1'b0;
        run_until_empty(40, "reset_mid");
    endtask

    task automatic test_wrap3();
        apply_reset();
        v3 = 3'b101;
        @(posedge clk); #1;
        checks++;
        if (grant3 !== 2'd0 || busy3 !== 1'b1 || rdy3 !== 3'b001) begin
            failures++;
            $display("FAIL wrap3_first: got grant=%0d busy=%b tready=%b, want 0 1 001", grant3, busy3, rdy3);
        end
        @(posedge clk); #1;
        v3 = 3'b100;
        checks++;
        if (busy3 !== 1'b0) begin failures++; $display("FAIL wrap3_idle: got busy=%b, want 0", busy3); end
        @(posedge clk); #1;
        checks++;
        if (grant3 !== 2'd2 || rdy3 !== 3'b100) begin
            failures++;
            $display("FAIL wrap3_port2: got grant=%0d tready=%b, want 2 100", grant3, rdy3);
        end
        @(posedge clk); #1;
        v3 = 3'b101;
        @(posedge clk); #1;
        checks++;
        if (grant3 !== 2'd0 || busy3 !== 1'b1) begin
            failures++;
            $display("FAIL wrap3_wrap: got grant=%0d busy=%b, want 0 1", grant3, busy3);
        end
        v3 = '0;
        @(posedge clk); #1;
    endtask

    initial begin
        src_valid  = '0;
        src_last   = '0;
        sink_ready = 1'b0;
        hold       = '0;
        bp_toggle  = 1'b0;
        v3         = '0;
        for (int k = 0; k < NP; k++) begin
            src_data[k] = '0;
            src_keep[k] = '0;
        end
        test_reset();
        test_two_ports();
        test_rr_single_beat();
        test_lock_hold();
        test_backpressure();
        test_reset_mid();
        test_wrap3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
